// File: rtl/ram_loader_pkg.sv
// Shared definitions for the RAM program loader.
// Optional checksum feature: define RAM_LOADER_CHECKSUM_EN.
package mc_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ADDR_W_DEF = 4;
    localparam int unsigned DEPTH      = 2 ** ADDR_W_DEF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DONE  = 2'd2
`ifdef RAM_LOADER_CHECKSUM_EN
        ,
        ST_CHECK = 2'd3
`endif
    } loader_state_t;

endpackage

// File: rtl/ram_loader_if.sv
// Source/RAM-side bundle of the loader.
// Optional checksum feature: define RAM_LOADER_CHECKSUM_EN (adds err).
interface ram_loader_if
    import mc_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
);
    logic              start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              busy;
    logic              done;
`ifdef RAM_LOADER_CHECKSUM_EN
    logic              err;
`endif

    // Controller / byte source side.
    modport master (
`ifdef RAM_LOADER_CHECKSUM_EN
        input  err,
`endif
        output start, in_valid, in_data,
        input  in_ready, mem_write, mem_addr, mem_data, busy, done
    );

    // Loader side.
    modport slave (
`ifdef RAM_LOADER_CHECKSUM_EN
        output err,
`endif
        input  start, in_valid, in_data,
        output in_ready, mem_write, mem_addr, mem_data, busy, done
    );

endinterface

// File: rtl/ram_loader_addr_counter.sv
// Write-address counter: clear, increment, saturates at the last address.
module load_addr_counter #(
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              inc,
    output logic [ADDR_W-1:0] count,
    output logic              last_c
);

    assign last_c = (count == {ADDR_W{1'b1}});

    // Count accepted bytes; holding at the top keeps it from wrapping in a load.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (inc && !last_c) begin
            count <= count + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/ram_loader.sv
// Streams DEPTH bytes from a valid/ready source into a RAM write port.
// Optional checksum feature: define RAM_LOADER_CHECKSUM_EN.
module ram_loader
    import mc_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    ram_loader_if.slave  bus
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    loader_state_t     state;
    logic [ADDR_W-1:0] count;
    logic              last_c;
    logic              clear_c;
    logic              accept_c;
`ifdef RAM_LOADER_CHECKSUM_EN
    logic [7:0]        sum;
`endif

    assign clear_c  = (state == ST_IDLE) && bus.start;
    assign accept_c = (state == ST_LOAD) && bus.in_ready && bus.in_valid;

    load_addr_counter #(.ADDR_W(ADDR_W)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear_c),
        .inc    (accept_c),
        .count  (count),
        .last_c (last_c)
    );

    // Loader FSM with registered handshake, RAM-port and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            bus.in_ready  <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_data  <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
`ifdef RAM_LOADER_CHECKSUM_EN
            bus.err       <= 1'b0;
            sum           <= 8'd0;
`endif
        end else begin
            bus.mem_write <= 1'b0;
            bus.done      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state        <= ST_LOAD;
                        bus.in_ready <= 1'b1;
                        bus.busy     <= 1'b1;
`ifdef RAM_LOADER_CHECKSUM_EN
                        bus.err      <= 1'b0;
                        sum          <= 8'd0;
`endif
                    end
                end
                ST_LOAD: begin
                    if (accept_c) begin
                        bus.mem_write <= 1'b1;
                        bus.mem_addr  <= count;
                        bus.mem_data  <= bus.in_data;
`ifdef RAM_LOADER_CHECKSUM_EN
                        sum           <= sum + 8'(bus.in_data);
                        if (last_c) begin
                            state <= ST_CHECK;
                        end
`else
                        if (last_c) begin
                            state        <= ST_DONE;
                            bus.in_ready <= 1'b0;
                            bus.busy     <= 1'b0;
                        end
`endif
                    end
                end
`ifdef RAM_LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    // Trailing checksum byte is compared, never written.
                    if (bus.in_valid && bus.in_ready) begin
                        bus.err      <= (8'(bus.in_data) != sum);
                        state        <= ST_DONE;
                        bus.in_ready <= 1'b0;
                        bus.busy     <= 1'b0;
                    end
                end
`endif
                ST_DONE: begin
                    bus.done <= 1'b1;
                    state    <= ST_IDLE;
                end
                default: begin
                    state        <= ST_IDLE;
                    bus.in_ready <= 1'b0;
                    bus.busy     <= 1'b0;
                end
            endcase
        end
    end

    logic unused_depth;
    assign unused_depth = (DEPTH == 0);

endmodule

// File: tb/tb_ram_loader.sv
// Randomized, model-checked bench for ram_loader.
// Honours RAM_LOADER_CHECKSUM_EN the same way as the RTL.
module tb_ram_loader;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;
`ifdef RAM_LOADER_CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [DW-1:0] in_data;

    ram_loader_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    assign bus.start    = start;
    assign bus.in_valid = in_valid;
    assign bus.in_data  = in_data;

    ram_loader #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
    endfunction

    // Reference model: loader phase 0 idle, 1 loading, 2 checksum byte, 3 finishing.
    int            ph = 0;
    int            m_addr = 0;
    logic [7:0]    m_sum = 8'd0;
    logic          e_write = 1'b0, e_done = 1'b0, e_busy = 1'b0, e_err = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_data = '0;
    logic [DW-1:0] exp_ram [DEPTH];
    logic [DW-1:0] dut_ram [DEPTH];
    int            cycle = 0;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            exp_ram[i] = '0;
            dut_ram[i] = '0;
        end
    end

    // Predict the outputs that follow each rising edge.
    always @(posedge clk) begin
        cycle++;
        e_write = 1'b0;
        e_done  = 1'b0;
        if (rst) begin
            ph = 0; m_addr = 0; m_sum = 8'd0; e_err = 1'b0;
        end else begin
            case (ph)
                0: if (start) begin ph = 1; m_addr = 0; m_sum = 8'd0; e_err = 1'b0; end
                1: if (in_valid) begin
                    e_write = 1'b1;
                    e_addr  = AW'(m_addr);
                    e_data  = in_data;
                    exp_ram[m_addr] = in_data;
                    m_sum   = m_sum + in_data;
                    if (m_addr == DEPTH - 1) ph = CHK ? 2 : 3;
                    else m_addr++;
                end
                2: if (in_valid) begin e_err = (in_data != m_sum); ph = 3; end
                default: begin e_done = 1'b1; ph = 0; end
            endcase
        end
        e_busy = (ph == 1 || ph == 2);
    end

    // Write/done monitor
    int wr_count = 0, first_wr_cyc = 0, last_wr_cyc = 0, last_wr_addr = 0;
    int done_count = 0, done_cyc = 0;

    // Per-cycle comparison against the model, plus monitor bookkeeping.
    always @(negedge clk) begin
        chk("mem_write", 32'(bus.mem_write), 32'(e_write));
        chk("busy",      32'(bus.busy),      32'(e_busy));
        chk("in_ready",  32'(bus.in_ready),  32'(e_busy));
        chk("done",      32'(bus.done),      32'(e_done));
`ifdef RAM_LOADER_CHECKSUM_EN
        chk("err",       32'(bus.err),       32'(e_err));
`endif
        if (e_write) begin
            chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
            chk("mem_data", 32'(bus.mem_data), 32'(e_data));
        end
        if (bus.mem_write) begin
            dut_ram[bus.mem_addr] = bus.mem_data;
            if (wr_count == 0) first_wr_cyc = cycle;
            wr_count++;
            last_wr_cyc  = cycle;
            last_wr_addr = int'(bus.mem_addr);
        end
        if (bus.done) begin
            done_count++;
            done_cyc = cycle;
        end
    end

    task automatic cyc(input logic s, input logic v, input logic [DW-1:0] d);
        start = s; in_valid = v; in_data = d;
        @(negedge clk); #1;
    endtask

    task automatic clear_mon();
        wr_count = 0; done_count = 0;
    endtask

    task automatic send_rand(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, DW'($urandom));
    endtask

    task automatic trailer();
        if (CHK) cyc(1'b0, 1'b1, DW'($urandom));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, DW'($urandom));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        @(negedge clk); #1;
        cyc(1'b1, 1'b1, 8'hFF);
        chk("reset_busy",  32'(bus.busy), 32'd0);
        chk("reset_write", 32'(bus.mem_write), 32'd0);
        rst = 1'b0;
        idle(2);

        // Basic load 0x10..0x1F
        clear_mon();
        cyc(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 8'(8'h10 + i));
        trailer();
        idle(3);
        chk("basic_wr_count", 32'(wr_count), 32'd16);
        chk("basic_consec",   32'(last_wr_cyc - first_wr_cyc), 32'd15);
        chk("basic_last_addr", 32'(last_wr_addr), 32'd15);
        chk("basic_done_cnt", 32'(done_count), 32'd1);
        chk("basic_done_lat", 32'(done_cyc - last_wr_cyc), CHK ? 32'd2 : 32'd1);
        chk("basic_ram0",  32'(dut_ram[0]),  32'h10);
        chk("basic_ram15", 32'(dut_ram[15]), 32'h1F);
        chk("model_ram7",  32'(exp_ram[7]),  32'h17);
        chk("basic_busy_after", 32'(bus.busy), 32'd0);

        // Backpressure gaps
        clear_mon();
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 8'hA5);
        cyc(1'b0, 1'b0, 8'h33);
        cyc(1'b0, 1'b0, 8'h44);
        cyc(1'b0, 1'b1, 8'h5A);
        cyc(1'b0, 1'b0, 8'h66);
        chk("bp_wr_count", 32'(wr_count), 32'd2);
        chk("bp_gap",      32'(last_wr_cyc - first_wr_cyc), 32'd3);
        chk("bp_ram0",     32'(dut_ram[0]), 32'hA5);
        chk("bp_ram1",     32'(dut_ram[1]), 32'h5A);
        chk("bp_last_addr", 32'(last_wr_addr), 32'd1);
        send_rand(14);
        trailer();
        idle(3);

        // Reset mid-load after 5 bytes
        clear_mon();
        cyc(1'b1, 1'b0, 8'h00);
        send_rand(5);
        chk("rml_wr_count", 32'(wr_count), 32'd5);
        chk("rml_last_addr", 32'(last_wr_addr), 32'd4);
        clear_mon();
        rst = 1'b1;
        send_rand(2);
        rst = 1'b0;
        send_rand(3);
        chk("rml_no_writes", 32'(wr_count), 32'd0);
        chk("rml_idle_busy", 32'(bus.busy), 32'd0);
        clear_mon();
        cyc(1'b1, 1'b0, 8'h00);
        send_rand(1);
        chk("rml_restart_addr", 32'(last_wr_addr), 32'd0);
        send_rand(15);
        trailer();
        idle(3);

        // start pulsed at byte 7 is ignored
        clear_mon();
        cyc(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) cyc(i == 7, 1'b1, DW'($urandom));
        trailer();
        idle(3);
        chk("sdl_done_cnt",  32'(done_count), 32'd1);
        chk("sdl_wr_count",  32'(wr_count), 32'd16);
        chk("sdl_last_addr", 32'(last_wr_addr), 32'd15);

`ifdef RAM_LOADER_CHECKSUM_EN
        // Checksum pass then fail
        clear_mon();
        cyc(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 8'h01);
        cyc(1'b0, 1'b1, 8'h10);
        idle(3);
        chk("cs_pass_err",  32'(bus.err), 32'd0);
        chk("cs_pass_done", 32'(done_count), 32'd1);
        clear_mon();
        cyc(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 8'h01);
        cyc(1'b0, 1'b1, 8'h11);
        idle(3);
        chk("cs_fail_err",  32'(bus.err), 32'd1);
        chk("cs_fail_wr",   32'(wr_count), 32'd16);
        chk("cs_fail_done", 32'(done_count), 32'd1);
        idle(4);
        chk("cs_err_hold",  32'(bus.err), 32'd1);
        cyc(1'b1, 1'b0, 8'h00);
        chk("cs_err_clear", 32'(bus.err), 32'd0);
        send_rand(16);
        trailer();
        idle(3);
`endif

        // Random traffic with occasional resets and stray starts
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            cyc($urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0, DW'($urandom));
        end
        rst = 1'b0;
        idle(4);

        for (int i = 0; i < DEPTH; i++) chk("ram_image", 32'(dut_ram[i]), 32'(exp_ram[i]));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
